// File: rtl/dpram_ls.sv
// dpram_ls: dual-port unified instruction/data RAM.
//
// Data port: sized loads/stores (byte/half/word/dword) at any byte alignment.
// Loads are sign- or zero-extended. An access that fits in one word completes
// in one cycle. An access that crosses a word boundary is split over two
// cycles (IDLE->SPLIT). Instruction port: aligned, registered, read-only fetch.
// Storage is big-endian: the lowest byte address maps to the MSB lane.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   d_req_i / d_ready_o            data request handshake
//   d_we_i, d_size_i, d_unsigned_i store/load, log2 size, zero-extend
//   d_addr_i, d_wdata_i            byte address, right-justified store data
//   d_ack_o, d_err_o, d_rdata_o    completion pulse, illegal size, load data
//   i_req_i, i_addr_i              fetch enable and address
//   i_rvalid_o, i_rdata_o          fetch result (latency 1)

// Per-lane slice. POS is the byte position inside the word currently being
// accessed, where 0 is the MSB lane. k = POS + base is the index of the
// access byte that lands here. Byte k of an S-byte value occupies bits
// [8*(S-1-k) +: 8] of the right-justified data.
module dpram_ls_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int KW         = 5,
  parameter int POS        = 0
) (
  input  logic signed [KW-1:0]  base,
  input  logic signed [KW-1:0]  size_b,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [7:0]            rbyte,
  output logic                  hit,
  output logic [7:0]            wbyte,
  output logic [DATA_WIDTH-1:0] rpart
);
  logic signed [KW-1:0]  k, sh;
  logic [KW+2:0]         shamt;
  logic [DATA_WIDTH-1:0] wsh;

  always_comb begin
    k     = $signed(KW'(POS)) + base;
    sh    = size_b - k - $signed(KW'(1));
    hit   = !k[KW-1] && (k < size_b);
    shamt = {sh, 3'b000};
    wsh   = wdata >> shamt;
    wbyte = wsh[7:0];
    rpart = hit ? ({{(DATA_WIDTH-8){1'b0}}, rbyte} << shamt) : '0;
  end
endmodule

module dpram_ls #(
  parameter int RAM_SIZE       = 4096,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  d_req_i,
  output logic                  d_ready_o,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int WIW   = RAM_ADDR_WIDTH - OFFW;
  localparam int WORDS = RAM_SIZE / NB;
  localparam int KW    = OFFW + 3;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  typedef struct packed {
    logic                  we;
    logic                  uns;
    logic [1:0]            sz;
    logic [OFFW-1:0]       off;
    logic [WIW-1:0]        word;
    logic [DATA_WIDTH-1:0] wdata;
  } dreq_t;

  logic [NB-1:0][7:0] mem [WORDS];

  state_t                        state, state_nxt;
  dreq_t                         in_req, lat_req;
  logic [WIW-1:0]                cur_word, i_word;
  logic [1:0]                    cur_sz;
  logic                          cur_uns;
  logic [DATA_WIDTH-1:0]         cur_wdata;
  logic [KW-1:0]                 in_size_b, cur_size_b;
  logic signed [KW-1:0]          base;
  logic                          in_err, in_cross, accept, wr_en;
  logic [NB-1:0][7:0]            rd_word;
  logic [NB-1:0]                 hit;
  logic [NB-1:0][7:0]            wbyte;
  logic [NB-1:0][DATA_WIDTH-1:0] rpart;
  logic [DATA_WIDTH-1:0]         ld_part, ld_full, ld_ext, hold;
  logic                          unused_addr;

  assign unused_addr = ^{d_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                         i_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH], i_addr_i[OFFW-1:0]};
  assign i_word = i_addr_i[RAM_ADDR_WIDTH-1:OFFW];

  // Keep the low 8*S bits, then fill the upper bits with zeros or the sign bit.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                   input logic [1:0] sz, input logic uns);
    logic [DATA_WIDTH-1:0] mask, sv;
    mask = ~({DATA_WIDTH{1'b1}} << (32'd8 << sz));
    sv   = v >> ((32'd8 << sz) - 32'd1);
    return (uns || !sv[0]) ? (v & mask) : ((v & mask) | ~mask);
  endfunction

  always_comb begin
    in_req.we    = d_we_i;
    in_req.uns   = d_unsigned_i;
    in_req.sz    = d_size_i;
    in_req.off   = d_addr_i[OFFW-1:0];
    in_req.word  = d_addr_i[RAM_ADDR_WIDTH-1:OFFW];
    in_req.wdata = d_wdata_i;
    in_size_b    = {{(KW-1){1'b0}}, 1'b1} << in_req.sz;
    in_err       = in_size_b > KW'(NB);
    in_cross     = (KW'(in_req.off) + in_size_b) > KW'(NB);

    d_ready_o = (state == IDLE) && !rst_i;
    accept    = d_req_i && d_ready_o;

    // The SPLIT cycle replays the latched request against the next word
    // (index wraps to 0 past the top). base is chosen so the access byte
    // that continues the sequence lands on position 0.
    if (state == SPLIT) begin
      cur_sz    = lat_req.sz;
      cur_uns   = lat_req.uns;
      cur_wdata = lat_req.wdata;
      cur_word  = lat_req.word + 1'b1;
      base      = $signed(KW'(NB)) - $signed(KW'(lat_req.off));
    end else begin
      cur_sz    = in_req.sz;
      cur_uns   = in_req.uns;
      cur_wdata = in_req.wdata;
      cur_word  = in_req.word;
      base      = -$signed(KW'(in_req.off));
    end
    cur_size_b = {{(KW-1){1'b0}}, 1'b1} << cur_sz;

    wr_en = (accept && in_req.we && !in_err) ||
            ((state == SPLIT) && lat_req.we && !rst_i);

    rd_word = mem[cur_word];
    ld_part = '0;
    for (int p = 0; p < NB; p++) ld_part = ld_part | rpart[OFFW'(p)];
    ld_full = (state == SPLIT) ? (hold | ld_part) : ld_part;
    ld_ext  = extend(ld_full, cur_sz, cur_uns);
  end

  for (genvar p = 0; p < NB; p++) begin : g_lane
    dpram_ls_lane #(.DATA_WIDTH(DATA_WIDTH), .KW(KW), .POS(p)) u_lane (
      .base   (base),
      .size_b ($signed(cur_size_b)),
      .wdata  (cur_wdata),
      .rbyte  (rd_word[NB-1-p]),
      .hit    (hit[p]),
      .wbyte  (wbyte[p]),
      .rpart  (rpart[p])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_err && in_cross) state_nxt = SPLIT;
      SPLIT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte-masked write; reads elsewhere see the pre-edge contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int p = 0; p < NB; p++)
        if (hit[OFFW'(p)]) mem[cur_word][OFFW'(NB-1-p)] <= wbyte[OFFW'(p)];
    end
  end

  // Split bookkeeping: request and first-word load bytes.
  always_ff @(posedge clk_i) begin
    if (accept && !in_err && in_cross) begin
      lat_req <= in_req;
      hold    <= ld_part;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      d_ack_o    <= 1'b0;
      d_err_o    <= 1'b0;
      d_rdata_o  <= '0;
      i_rvalid_o <= 1'b0;
      i_rdata_o  <= '0;
    end else begin
      state      <= state_nxt;
      d_ack_o    <= 1'b0;
      d_err_o    <= 1'b0;
      i_rvalid_o <= i_req_i;
      if (i_req_i) i_rdata_o <= mem[i_word];
      if (state == SPLIT) begin
        d_ack_o   <= 1'b1;
        d_rdata_o <= lat_req.we ? '0 : ld_ext;
      end else if (accept) begin
        if (in_err) begin
          d_ack_o   <= 1'b1;
          d_err_o   <= 1'b1;
          d_rdata_o <= '0;
        end else if (!in_cross) begin
          d_ack_o   <= 1'b1;
          d_rdata_o <= in_req.we ? '0 : ld_ext;
        end
      end
    end
  end

  // Simulation preload of one byte, big-endian placement, address wrapped.
  task automatic writeByte(input logic [ADDR_WIDTH-1:0] byte_addr, input logic [7:0] val);
    logic [RAM_ADDR_WIDTH-1:0] a;
    a = byte_addr[RAM_ADDR_WIDTH-1:0];
    mem[a[RAM_ADDR_WIDTH-1:OFFW]][~a[OFFW-1:0]] <= val;
  endtask
endmodule

// File: tb/tb_dpram_ls.sv
module tb_dpram_ls;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          d_req_i, d_ready_o, d_we_i, d_unsigned_i;
  logic [1:0]    d_size_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_ack_o, d_err_o;
  logic [DW-1:0] d_rdata_o;
  logic          i_req_i, i_rvalid_o;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_rdata_o;

  dpram_ls #(.RAM_SIZE(4096), .RAM_ADDR_WIDTH(12), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_ready_o(d_ready_o), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_unsigned_i(d_unsigned_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rdata_o(d_rdata_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int lat,
                     input logic err, input logic [31:0] rd);
    vec_t v;
    v.name = n; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.lat = lat; v.err = err; v.rdata = rd;
    vt.push_back(v);
  endtask

  // Issue one request, then wait (bounded) for the ack, checking that the
  // port stays busy in between. Inputs are scrambled once accepted so a
  // split access must rely on its own latched copy.
  task automatic run_vec(input vec_t v);
    int lat;
    d_we_i = v.we; d_size_i = v.sz; d_unsigned_i = v.uns;
    d_addr_i = v.addr; d_wdata_i = v.wdata; d_req_i = 1'b1;
    step();
    d_req_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_size_i = 2'd0;
    lat = 1;
    while (!d_ack_o && lat < 4) begin
      chk({v.name, " ready_in_split"}, {63'd0, d_ready_o}, 64'd0);
      step();
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " err"}, {63'd0, d_err_o}, {63'd0, v.err});
    chk({v.name, " rdata"}, {32'd0, d_rdata_o}, {32'd0, v.rdata});
    chk({v.name, " ready_after"}, {63'd0, d_ready_o}, 64'd1);
  endtask

  task automatic run_one(input string n, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         input logic err, input logic [31:0] rd);
    vec_t v;
    v.name = n; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.lat = lat; v.err = err; v.rdata = rd;
    run_vec(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = 2'd0; d_unsigned_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; i_req_i = 1'b0; i_addr_i = '0;

    //   name           we sz uns addr          wdata         lat err rdata
    add("st_w_10",      1, 2, 0, 32'h0000_0010, 32'hDEADBEEF, 1, 0, 32'h0);
    add("ld_w_10",      0, 2, 0, 32'h0000_0010, 32'h0,        1, 0, 32'hDEADBEEF);
    add("ld_bs_10",     0, 0, 0, 32'h0000_0010, 32'h0,        1, 0, 32'hFFFFFFDE);
    add("ld_bu_11",     0, 0, 1, 32'h0000_0011, 32'h0,        1, 0, 32'h000000AD);
    add("ld_hs_12",     0, 1, 0, 32'h0000_0012, 32'h0,        1, 0, 32'hFFFFBEEF);
    add("ld_hu_12",     0, 1, 1, 32'h0000_0012, 32'h0,        1, 0, 32'h0000BEEF);
    add("st_b_12",      1, 0, 0, 32'h0000_0012, 32'h1234565A, 1, 0, 32'h0);
    add("ld_w_10b",     0, 2, 0, 32'h0000_0010, 32'h0,        1, 0, 32'hDEAD5AEF);
    add("ld_bs_12",     0, 0, 0, 32'h0000_0012, 32'h0,        1, 0, 32'h0000005A);
    add("st_w_0e_spl",  1, 2, 0, 32'h0000_000E, 32'h11223344, 2, 0, 32'h0);
    add("ld_w_0e_spl",  0, 2, 0, 32'h0000_000E, 32'h0,        2, 0, 32'h11223344);
    add("ld_hu_0e",     0, 1, 1, 32'h0000_000E, 32'h0,        1, 0, 32'h00001122);
    add("ld_hs_0f_spl", 0, 1, 0, 32'h0000_000F, 32'h0,        2, 0, 32'h00002233);
    add("ld_w_10c",     0, 2, 0, 32'h0000_0010, 32'h0,        1, 0, 32'h33445AEF);
    add("ld_w_alias",   0, 2, 1, 32'hABCD_1010, 32'h0,        1, 0, 32'h33445AEF);
    add("st_h_wrap",    1, 1, 0, 32'h0000_0FFF, 32'h0000ABCD, 2, 0, 32'h0);
    add("ld_hu_wrap",   0, 1, 1, 32'h0000_0FFF, 32'h0,        2, 0, 32'h0000ABCD);
    add("ld_hs_wrap",   0, 1, 0, 32'h0000_0FFF, 32'h0,        2, 0, 32'hFFFFABCD);
    add("ld_bu_000",    0, 0, 1, 32'h0000_0000, 32'h0,        1, 0, 32'h000000CD);
    add("ld_bs_fff",    0, 0, 0, 32'h0000_0FFF, 32'h0,        1, 0, 32'hFFFFFFAB);
    add("st_d_err",     1, 3, 0, 32'h0000_0010, 32'hFFFFFFFF, 1, 1, 32'h0);
    add("ld_d_err",     0, 3, 0, 32'h0000_0010, 32'h0,        1, 1, 32'h0);
    add("ld_w_after_e", 0, 2, 0, 32'h0000_0010, 32'h0,        1, 0, 32'h33445AEF);
    add("st_w_21_spl",  1, 2, 0, 32'h0000_0021, 32'h80000001, 2, 0, 32'h0);
    add("ld_w_21_spl",  0, 2, 0, 32'h0000_0021, 32'h0,        2, 0, 32'h80000001);
    add("ld_bs_24",     0, 0, 0, 32'h0000_0024, 32'h0,        1, 0, 32'h00000001);
    add("ld_hs_21",     0, 1, 0, 32'h0000_0021, 32'h0,        1, 0, 32'hFFFF8000);
    add("ld_hu_23_spl", 0, 1, 1, 32'h0000_0023, 32'h0,        2, 0, 32'h00000001);

    // Reset state
    step(); step();
    chk("rst ack", {63'd0, d_ack_o}, 64'd0);
    chk("rst err", {63'd0, d_err_o}, 64'd0);
    chk("rst rdata", {32'd0, d_rdata_o}, 64'd0);
    chk("rst i_rvalid", {63'd0, i_rvalid_o}, 64'd0);
    chk("rst i_rdata", {32'd0, i_rdata_o}, 64'd0);
    chk("rst ready_low", {63'd0, d_ready_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    chk("rst ready_high", {63'd0, d_ready_o}, 64'd1);

    foreach (vt[i]) run_vec(vt[i]);

    // Fetch port: hit, then idle (valid drops, data holds)
    i_req_i = 1'b1; i_addr_i = 32'h0000_0013;
    step();
    chk("fetch_13 valid", {63'd0, i_rvalid_o}, 64'd1);
    chk("fetch_13 data", {32'd0, i_rdata_o}, {32'd0, 32'h33445AEF});
    i_req_i = 1'b0; i_addr_i = 32'h0000_0020;
    step();
    chk("fetch_idle valid", {63'd0, i_rvalid_o}, 64'd0);
    chk("fetch_idle hold", {32'd0, i_rdata_o}, {32'd0, 32'h33445AEF});

    // Same-edge store and fetch of one word: fetch returns old data
    d_we_i = 1'b1; d_size_i = 2'd2; d_unsigned_i = 1'b0; d_addr_i = 32'h0000_0010;
    d_wdata_i = 32'h01020304; d_req_i = 1'b1;
    i_req_i = 1'b1; i_addr_i = 32'h0000_0010;
    step();
    d_req_i = 1'b0;
    chk("coll ack", {63'd0, d_ack_o}, 64'd1);
    chk("coll fetch_old", {32'd0, i_rdata_o}, {32'd0, 32'h33445AEF});
    step();
    chk("coll fetch_new", {32'd0, i_rdata_o}, {32'd0, 32'h01020304});
    i_req_i = 1'b0;
    run_one("ld_w_coll", 0, 2, 0, 32'h0000_0010, 32'h0, 1, 0, 32'h01020304);

    // Reset during the SPLIT cycle of a crossing store
    d_we_i = 1'b1; d_size_i = 2'd2; d_addr_i = 32'h0000_000E; d_wdata_i = 32'h55667788;
    d_req_i = 1'b1;
    step();
    d_req_i = 1'b0;
    chk("rsplit first ack", {63'd0, d_ack_o}, 64'd0);
    chk("rsplit busy", {63'd0, d_ready_o}, 64'd0);
    rst_i = 1'b1;
    step();
    chk("rsplit ack", {63'd0, d_ack_o}, 64'd0);
    chk("rsplit rdata", {32'd0, d_rdata_o}, 64'd0);
    chk("rsplit i_rdata", {32'd0, i_rdata_o}, 64'd0);
    chk("rsplit i_rvalid", {63'd0, i_rvalid_o}, 64'd0);
    chk("rsplit ready_in_rst", {63'd0, d_ready_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    chk("rsplit ready", {63'd0, d_ready_o}, 64'd1);
    run_one("rsplit ld_w_10", 0, 2, 0, 32'h0000_0010, 32'h0, 1, 0, 32'h01020304);
    run_one("rsplit ld_hu_0e", 0, 1, 1, 32'h0000_000E, 32'h0, 1, 0, 32'h00005566);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
